pc_dispatch_buffer: RTL and testbench

- Thread scheduler that sits directly downstream of basic_block and closes the loop back to its input.
- Captures every output_pc that basic_block produces. Each PC goes into a "current character" queue or a "next character" queue, selected by output_pc_is_directed_to_current.
- Feeds current-queue PCs back to basic_block input_pc.
- When the current character has no threads left, requests a character advance and swaps the queues. Asserts done when no thread survives.

---
 rtl/pc_dispatch_buffer.sv | 147 ++++++++++++++
 tb/tb_pc_dispatch_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_dispatch_buffer.sv
// Thread dispatch buffer closing the basic_block loop: two circular PC queues
// (current / next character) with a small sequencer for character advance and done detection.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | after reset; threads may be seeded, nothing dispatched
// RUN     | dispatch current-queue PCs, capture returned PCs into either queue
// ADVANCE | current character exhausted; wait for the character stream to step
// DONE    | no live threads; seeding allowed, start re-enters RUN
module pc_dispatch_buffer #(
    parameter int PC_WIDTH        = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_pc_valid,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                in_pc_is_directed_to_current,
    output logic                in_pc_ready,
    output logic                out_pc_valid,
    output logic [PC_WIDTH-1:0] out_pc,
    input  logic                out_pc_ready,
    input  logic                core_busy,
    output logic                advance_valid,
    input  logic                advance_ready,
    output logic                done
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {PTR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                     cur_sel;
    logic                     rdy_en;
    logic [1:0]               q_push;
    logic [1:0]               q_pop;
    logic [1:0]               q_empty;
    logic [1:0]               q_full;
    logic [1:0][PC_WIDTH-1:0] q_head;

    logic cur_empty, cur_full, next_empty, next_full;
    logic push_en, pop_en, push_sel;
    logic in_rdy_c, out_vld_c, adv_vld_c, done_c;

    assign cur_empty  = q_empty[cur_sel];
    assign cur_full   = q_full[cur_sel];
    assign next_empty = q_empty[~cur_sel];
    assign next_full  = q_full[~cur_sel];

    assign push_en  = in_pc_valid && in_pc_ready;
    assign pop_en   = out_pc_valid && out_pc_ready;
    assign push_sel = in_pc_is_directed_to_current ? cur_sel : ~cur_sel;

    generate
        for (genvar q = 0; q < 2; q++) begin : g_queue
            logic [PC_WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0]    rd_ptr;
            logic [PTR_W-1:0]    wr_ptr;
            logic [CNT_W-1:0]    count;

            assign q_push[q]  = push_en && (push_sel == 1'(q));
            assign q_pop[q]   = pop_en && (cur_sel == 1'(q));
            assign q_empty[q] = (count == '0);
            assign q_full[q]  = (count == FULL_CNT);
            assign q_head[q]  = mem[rd_ptr];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (q_push[q]) wr_ptr <= wr_ptr + PTR_W'(1);
                    if (q_pop[q])  rd_ptr <= rd_ptr + PTR_W'(1);
                    count <= count + CNT_W'(q_push[q]) - CNT_W'(q_pop[q]);
                end
            end

            // Storage is not reset; a cleared count makes stale entries unreachable.
            always_ff @(posedge clk) begin
                if (q_push[q]) mem[wr_ptr] <= in_pc;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cur_sel <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (state == ST_ADVANCE && advance_ready) cur_sel <= ~cur_sel;
        end
    end

    always_comb begin
        state_nxt = state;
        in_rdy_c  = 1'b0;
        out_vld_c = 1'b0;
        adv_vld_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_rdy_c = !cur_full && !next_full;
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Readiness ignores the directed flag so either queue can always absorb a PC.
                in_rdy_c  = !cur_full && !next_full;
                out_vld_c = !cur_empty;
                if (cur_empty && !core_busy && !in_pc_valid)
                    state_nxt = next_empty ? ST_DONE : ST_ADVANCE;
            end
            ST_ADVANCE: begin
                adv_vld_c = 1'b1;
                if (advance_ready) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                done_c   = 1'b1;
                in_rdy_c = !cur_full && !next_full;
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rdy_en holds in_pc_ready low while reset is applied and until the first clock after it.
    assign in_pc_ready   = in_rdy_c && rdy_en;
    assign out_pc_valid  = out_vld_c;
    assign out_pc        = out_vld_c ? q_head[cur_sel] : '0;
    assign advance_valid = adv_vld_c;
    assign done          = done_c;

endmodule

// File: tb/tb_pc_dispatch_buffer.sv
// Directed self-checking bench for pc_dispatch_buffer: seeding, advance, ordering,
// full queue, simultaneous push/pop and mid-run reset.
module tb_pc_dispatch_buffer;

    localparam int PC_WIDTH = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                in_pc_valid = 1'b0;
    logic [PC_WIDTH-1:0] in_pc = '0;
    logic                in_pc_is_directed_to_current = 1'b0;
    logic                in_pc_ready;
    logic                out_pc_valid;
    logic [PC_WIDTH-1:0] out_pc;
    logic                out_pc_ready = 1'b0;
    logic                core_busy = 1'b0;
    logic                advance_valid;
    logic                advance_ready = 1'b0;
    logic                done;

    int n_chk  = 0;
    int n_fail = 0;

    pc_dispatch_buffer #(.PC_WIDTH(PC_WIDTH), .FIFO_DEPTH_LOG2(4)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .start                        (start),
        .in_pc_valid                  (in_pc_valid),
        .in_pc                        (in_pc),
        .in_pc_is_directed_to_current (in_pc_is_directed_to_current),
        .in_pc_ready                  (in_pc_ready),
        .out_pc_valid                 (out_pc_valid),
        .out_pc                       (out_pc),
        .out_pc_ready                 (out_pc_ready),
        .core_busy                    (core_busy),
        .advance_valid                (advance_valid),
        .advance_ready                (advance_ready),
        .done                         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc, input logic dir);
        in_pc_valid = 1'b1;
        in_pc = pc;
        in_pc_is_directed_to_current = dir;
        step();
        in_pc_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #3;
        chk("rst_out_vld", 32'(out_pc_valid), 0);
        chk("rst_out_pc", 32'(out_pc), 0);
        chk("rst_in_rdy", 32'(in_pc_ready), 0);
        chk("rst_adv", 32'(advance_valid), 0);
        chk("rst_done", 32'(done), 0);
        step();
        reset = 1'b1;
        step();
        step();
        chk("idle_in_rdy", 32'(in_pc_ready), 1);

        // 1: seed, start, dispatch, done
        push(8'h10, 1'b1);
        chk("t1_idle_no_out", 32'(out_pc_valid), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_out_vld", 32'(out_pc_valid), 1);
        chk("t1_out_pc", 32'(out_pc), 32'h10);
        chk("t1_adv0", 32'(advance_valid), 0);
        core_busy = 1'b1;
        out_pc_ready = 1'b1;
        step();
        out_pc_ready = 1'b0;
        chk("t1_drained", 32'(out_pc_valid), 0);
        chk("t1_busy_not_done", 32'(done), 0);
        chk("t1_adv1", 32'(advance_valid), 0);
        core_busy = 1'b0;
        step();
        chk("t1_done", 32'(done), 1);
        chk("t1_adv2", 32'(advance_valid), 0);
        step();
        chk("t1_done_sticky", 32'(done), 1);

        // 2: next-queue PC triggers advance
        core_busy = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_done_clr", 32'(done), 0);
        push(8'h20, 1'b0);
        chk("t2_no_out", 32'(out_pc_valid), 0);
        core_busy = 1'b0;
        step();
        chk("t2_adv", 32'(advance_valid), 1);
        chk("t2_adv_in_rdy", 32'(in_pc_ready), 0);
        chk("t2_adv_out_vld", 32'(out_pc_valid), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t2_adv_held", 32'(advance_valid), 1);
        advance_ready = 1'b1;
        step();
        advance_ready = 1'b0;
        chk("t2_adv_drop", 32'(advance_valid), 0);
        chk("t2_out_vld", 32'(out_pc_valid), 1);
        chk("t2_out_pc", 32'(out_pc), 32'h20);
        core_busy = 1'b1;
        out_pc_ready = 1'b1;
        step();
        out_pc_ready = 1'b0;

        // 3: FIFO order
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        chk("t3_head_hold", 32'(out_pc), 32'h01);
        out_pc_ready = 1'b1;
        chk("t3_pop0", 32'(out_pc), 32'h01);
        step();
        chk("t3_pop1", 32'(out_pc), 32'h02);
        step();
        chk("t3_pop2", 32'(out_pc), 32'h03);
        step();
        out_pc_ready = 1'b0;
        chk("t3_empty", 32'(out_pc_valid), 0);

        // 4: fill next queue to 16, reject 17th, then drain exactly 16
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t4_rdy_before_16th", 32'(in_pc_ready), 1);
            push(8'(8'h80 + i), 1'b0);
        end
        chk("t4_full_rdy", 32'(in_pc_ready), 0);
        push(8'hEE, 1'b0);
        chk("t4_full_rdy_hold", 32'(in_pc_ready), 0);
        core_busy = 1'b0;
        step();
        chk("t4_adv", 32'(advance_valid), 1);
        advance_ready = 1'b1;
        step();
        advance_ready = 1'b0;
        core_busy = 1'b1;
        chk("t4_cur_full_rdy", 32'(in_pc_ready), 0);
        out_pc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain_vld", 32'(out_pc_valid), 1);
            chk("t4_drain_pc", 32'(out_pc), 32'(8'h80 + i));
            step();
        end
        out_pc_ready = 1'b0;
        chk("t4_count16", 32'(out_pc_valid), 0);
        chk("t4_rdy_back", 32'(in_pc_ready), 1);

        // 5: simultaneous push and pop on current queue
        push(8'h55, 1'b1);
        chk("t5_head", 32'(out_pc), 32'h55);
        out_pc_ready = 1'b1;
        in_pc_valid = 1'b1;
        in_pc = 8'h66;
        in_pc_is_directed_to_current = 1'b1;
        step();
        in_pc_valid = 1'b0;
        chk("t5_vld", 32'(out_pc_valid), 1);
        chk("t5_new_pc", 32'(out_pc), 32'h66);
        step();
        out_pc_ready = 1'b0;
        chk("t5_count1", 32'(out_pc_valid), 0);

        // 6: reset mid-RUN with 5 queued
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b0);
        push(8'hA4, 1'b1);
        push(8'hA5, 1'b0);
        chk("t6_pre_vld", 32'(out_pc_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_out_vld", 32'(out_pc_valid), 0);
        chk("t6_rst_adv", 32'(advance_valid), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_in_rdy", 32'(in_pc_ready), 0);
        step();
        #2;
        reset = 1'b1;
        step();
        step();
        core_busy = 1'b0;
        chk("t6_idle_out_vld", 32'(out_pc_valid), 0);
        chk("t6_idle_in_rdy", 32'(in_pc_ready), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_run_no_stale", 32'(out_pc_valid), 0);
        chk("t6_run_pc", 32'(out_pc), 0);
        step();
        chk("t6_done", 32'(done), 1);
        chk("t6_done_no_adv", 32'(advance_valid), 0);

        // done -> start with empty queues returns to DONE after one RUN cycle
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t7_run_cycle", 32'(done), 0);
        step();
        chk("t7_back_done", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
